// File: rtl/light_map_pkg.sv
// Shared defaults and transmit state encoding for the light map stage.
package light_map_pkg;

    localparam int ZONES_DEF = 360;
    localparam int DW_DEF    = 16;
    localparam int IDX_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } tx_state_e;

endpackage

// File: rtl/light_map_tx_if.sv
// Filter-side write bus: per-zone light words plus the end-of-frame strobe.
interface light_map_tx_if
    import light_map_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int IDX_W = IDX_W_DEF
);
    logic [DW-1:0]    light;
    logic [IDX_W-1:0] light_index;
    logic             get_map;
    logic             filter_end;

    modport master (
        output light,
        output light_index,
        output get_map,
        output filter_end
    );

    modport slave (
        input light,
        input light_index,
        input get_map,
        input filter_end
    );
endinterface

// File: rtl/light_map_ram.sv
// Two-bank light map storage: simple dual-port RAM, registered read, {bank, index} addressing.
module light_map_ram
    import light_map_pkg::*;
#(
    parameter int ZONES = ZONES_DEF,
    parameter int DW    = DW_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             sys_clk,
    input  logic             we,
    input  logic [IDX_W:0]   waddr,
    input  logic [DW-1:0]    wdata,
    input  logic             re,
    input  logic [IDX_W:0]   raddr,
    output logic [DW-1:0]    rdata
);
    localparam int DEPTH = 2 * ZONES;
    localparam int AW    = $clog2(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_r;
    logic [AW-1:0] wlin_s;
    logic [AW-1:0] rlin_s;

    // Bank 1 lives directly above bank 0, so only 2*ZONES words are stored.
    function automatic logic [AW-1:0] lin_addr(input logic [IDX_W:0] a);
        logic [AW-1:0] base;
        if (a[IDX_W]) begin
            base = AW'(ZONES);
        end else begin
            base = {AW{1'b0}};
        end
        return base + AW'(a[IDX_W-1:0]);
    endfunction

    assign wlin_s = lin_addr(waddr);
    assign rlin_s = lin_addr(raddr);
    assign rdata  = rdata_r;

    // Write port and registered read; a same-address write is forwarded to the read.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem_r[wlin_s] <= wdata;
        end
        if (re) begin
            if (we && (waddr == raddr)) begin
                rdata_r <= wdata;
            end else begin
                rdata_r <= mem_r[rlin_s];
            end
        end
    end

endmodule

// File: rtl/light_map_tx.sv
// Double-buffered light map capture and serial streaming to the LED driver chain.
module light_map_tx
    import light_map_pkg::*;
#(
    parameter int ZONES      = ZONES_DEF,
    parameter int DW         = DW_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int CLK_DIV    = 4,
    parameter int LAT_CYCLES = 8
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    light_map_tx_if.slave   map_bus,
    output logic            led_sclk,
    output logic            led_sdi,
    output logic            led_lat,
    output logic            tx_busy,
    output logic            frame_drop
);
    localparam int SW = $clog2(2 * CLK_DIV);
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int LW = $clog2(LAT_CYCLES) + 1;

    localparam logic [SW-1:0]    SUB_LAST  = SW'(2 * CLK_DIV - 1);
    localparam logic [SW-1:0]    SUB_HALF  = SW'(CLK_DIV - 1);
    localparam logic [BW-1:0]    BIT_LAST  = BW'(DW - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(ZONES - 1);
    localparam logic [LW-1:0]    LAT_LAST  = LW'(LAT_CYCLES - 1);

    tx_state_e        state_r;
    tx_state_e        state_next_s;
    logic             wr_sel_r;
    logic             pending_r;
    logic             tx_busy_r;
    logic             frame_drop_r;
    logic             sclk_r;
    logic             lat_r;
    logic [DW-1:0]    shift_r;
    logic [SW-1:0]    sub_cnt_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [IDX_W-1:0] word_cnt_r;
    logic [LW-1:0]    lat_cnt_r;

    logic             busy_s;
    logic             bit_end_s;
    logic             word_end_s;
    logic             frame_end_s;
    logic             tx_done_s;
    logic             swap_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             rd_bank_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [DW-1:0]    rd_data_s;

    assign wr_en_s = map_bus.get_map && (map_bus.light_index < IDX_W'(ZONES));

    light_map_ram #(
        .ZONES (ZONES),
        .DW    (DW),
        .IDX_W (IDX_W)
    ) u_ram (
        .sys_clk (sys_clk),
        .we      (wr_en_s),
        .waddr   ({wr_sel_r, map_bus.light_index}),
        .wdata   (map_bus.light),
        .re      (rd_en_s),
        .raddr   ({rd_bank_s, rd_idx_s}),
        .rdata   (rd_data_s)
    );

    // Next-state decode and frame start/restart/swap conditions
    always_comb begin
        state_next_s = state_r;
        busy_s       = (state_r != IDLE);
        bit_end_s    = (state_r == SHIFT) && (sub_cnt_r == SUB_LAST);
        word_end_s   = bit_end_s && (bit_cnt_r == BIT_LAST);
        frame_end_s  = word_end_s && (word_cnt_r == WORD_LAST);
        tx_done_s    = (state_r == LATCH) && (lat_cnt_r == LAT_LAST);
        // A filter_end landing on the final LATCH cycle restarts directly instead of pending.
        swap_s       = ((state_r == IDLE) && map_bus.filter_end) ||
                       (tx_done_s && (pending_r || map_bus.filter_end));
        case (state_r)
            IDLE: begin
                if (map_bus.filter_end) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                state_next_s = SHIFT;
            end
            SHIFT: begin
                if (frame_end_s) begin
                    state_next_s = LATCH;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            LATCH: begin
                if (tx_done_s && (pending_r || map_bus.filter_end)) begin
                    state_next_s = LOAD;
                end else if (tx_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LATCH;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Read port: word 0 is fetched as a frame starts, later words during the last bit of the previous one
    always_comb begin
        rd_en_s   = 1'b0;
        rd_idx_s  = {IDX_W{1'b0}};
        rd_bank_s = ~wr_sel_r;
        if (swap_s) begin
            rd_en_s   = 1'b1;
            rd_bank_s = wr_sel_r;
        end else if ((state_r == SHIFT) && (bit_cnt_r == BIT_LAST) &&
                     (sub_cnt_r == {SW{1'b0}}) && (word_cnt_r != WORD_LAST)) begin
            rd_en_s  = 1'b1;
            rd_idx_s = word_cnt_r + IDX_W'(1);
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bank select, pending frame flag and status outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_sel_r     <= 1'b0;
            pending_r    <= 1'b0;
            tx_busy_r    <= 1'b0;
            frame_drop_r <= 1'b0;
        end else begin
            if (swap_s) begin
                wr_sel_r  <= ~wr_sel_r;
                pending_r <= 1'b0;
            end else if (map_bus.filter_end && busy_s) begin
                pending_r <= 1'b1;
            end
            tx_busy_r    <= (state_next_s != IDLE);
            frame_drop_r <= map_bus.filter_end && busy_s && pending_r;
        end
    end

    // Serializer counters, data shift register and LED line registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sub_cnt_r  <= {SW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            word_cnt_r <= {IDX_W{1'b0}};
            lat_cnt_r  <= {LW{1'b0}};
            shift_r    <= {DW{1'b0}};
            sclk_r     <= 1'b0;
            lat_r      <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    shift_r    <= rd_data_s;
                    sub_cnt_r  <= {SW{1'b0}};
                    bit_cnt_r  <= {BW{1'b0}};
                    word_cnt_r <= {IDX_W{1'b0}};
                    lat_cnt_r  <= {LW{1'b0}};
                    sclk_r     <= 1'b0;
                    lat_r      <= 1'b0;
                end
                SHIFT: begin
                    if (bit_end_s) begin
                        sub_cnt_r <= {SW{1'b0}};
                        sclk_r    <= 1'b0;
                        if (frame_end_s) begin
                            shift_r   <= {DW{1'b0}};
                            lat_r     <= 1'b1;
                            lat_cnt_r <= {LW{1'b0}};
                        end else if (word_end_s) begin
                            shift_r    <= rd_data_s;
                            bit_cnt_r  <= {BW{1'b0}};
                            word_cnt_r <= word_cnt_r + IDX_W'(1);
                        end else begin
                            shift_r   <= {shift_r[DW-2:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                        end
                    end else begin
                        sub_cnt_r <= sub_cnt_r + SW'(1);
                        sclk_r    <= sclk_r | (sub_cnt_r == SUB_HALF);
                    end
                end
                LATCH: begin
                    sclk_r <= 1'b0;
                    if (tx_done_s) begin
                        lat_r <= 1'b0;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LW'(1);
                    end
                end
                default: begin
                    sclk_r <= 1'b0;
                    lat_r  <= 1'b0;
                end
            endcase
        end
    end

    assign led_sclk   = sclk_r;
    assign led_sdi    = shift_r[DW-1];
    assign led_lat    = lat_r;
    assign tx_busy    = tx_busy_r;
    assign frame_drop = frame_drop_r;

endmodule

// File: tb/tb_light_map_tx.sv
// Self-checking bench: serial receiver monitor plus a frame-snapshot reference model.
module tb_light_map_tx;
    localparam int ZONES      = 4;
    localparam int DW         = 16;
    localparam int IDX_W      = 3;
    localparam int CLK_DIV    = 1;
    localparam int LAT_CYCLES = 2;
    localparam int FW         = ZONES * DW;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic led_sclk, led_sdi, led_lat, tx_busy, frame_drop;

    light_map_tx_if #(.DW(DW), .IDX_W(IDX_W)) map_bus ();

    light_map_tx #(
        .ZONES(ZONES), .DW(DW), .IDX_W(IDX_W), .CLK_DIV(CLK_DIV), .LAT_CYCLES(LAT_CYCLES)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .map_bus    (map_bus),
        .led_sclk   (led_sclk),
        .led_sdi    (led_sdi),
        .led_lat    (led_lat),
        .tx_busy    (tx_busy),
        .frame_drop (frame_drop)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int drop_cnt = 0;
    logic [DW-1:0] model_words [ZONES];
    logic [FW-1:0] rx_q [$];
    int rx_bits_q [$];
    int first_rise_q [$];
    int lat_fall_q [$];
    logic busy_fall_q [$];

    initial forever begin
        @(posedge sys_clk);
        cyc = cyc + 1;
    end

    // Receiver: shift in sdi on each sclk rise, close a frame on the latch rise
    initial begin
        logic prev_sclk, prev_lat;
        logic [FW-1:0] bits;
        int nbits;
        prev_sclk = 1'b0; prev_lat = 1'b0; bits = '0; nbits = 0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                nbits = 0;
                bits = '0;
            end else begin
                if (led_sclk && !prev_sclk) begin
                    if (nbits == 0) first_rise_q.push_back(cyc);
                    bits = {bits[FW-2:0], led_sdi};
                    nbits = nbits + 1;
                end
                if (led_lat && !prev_lat) begin
                    rx_q.push_back(bits);
                    rx_bits_q.push_back(nbits);
                    nbits = 0;
                end
                if (!led_lat && prev_lat) begin
                    lat_fall_q.push_back(cyc);
                    busy_fall_q.push_back(tx_busy);
                end
                if (frame_drop) drop_cnt = drop_cnt + 1;
            end
            prev_sclk = led_sclk;
            prev_lat = led_lat;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] pack_model();
        logic [FW-1:0] r;
        for (int i = 0; i < ZONES; i++) r[(ZONES-1-i)*DW +: DW] = model_words[i];
        return r;
    endfunction

    task automatic clear_rx();
        rx_q.delete(); rx_bits_q.delete(); first_rise_q.delete();
        lat_fall_q.delete(); busy_fall_q.delete(); drop_cnt = 0;
    endtask

    task automatic write_word(input int idx, input logic [DW-1:0] val);
        map_bus.get_map = 1'b1;
        map_bus.light_index = IDX_W'(idx);
        map_bus.light = val;
        if (idx < ZONES) model_words[idx] = val;
        @(negedge sys_clk);
        map_bus.get_map = 1'b0;
    endtask

    task automatic write_random_frame();
        for (int i = 0; i < ZONES; i++) write_word(i, DW'($urandom));
    endtask

    // Returns at the cycle after filter_end was sampled
    task automatic end_frame(output logic [FW-1:0] snap);
        map_bus.filter_end = 1'b1;
        snap = pack_model();
        @(negedge sys_clk);
        map_bus.filter_end = 1'b0;
    endtask

    task automatic wait_rx(input int n, output bit ok);
        int b = 0;
        while (rx_q.size() < n && b < 2000) begin
            @(negedge sys_clk);
            b++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_idle();
        int b = 0;
        while (tx_busy && b < 2000) begin
            @(negedge sys_clk);
            b++;
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        tests++; if (led_sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b expected 0", led_sclk); end
        tests++; if (led_sdi !== 1'b0) begin fails++; $display("FAIL reset_sdi: got %b expected 0", led_sdi); end
        tests++; if (led_lat !== 1'b0) begin fails++; $display("FAIL reset_lat: got %b expected 0", led_lat); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        tests++; if (frame_drop !== 1'b0) begin fails++; $display("FAIL reset_drop: got %b expected 0", frame_drop); end
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %b expected 0", tx_busy); end
    endtask

    task automatic test_basic_frame();
        logic [FW-1:0] snap;
        logic [FW-1:0] golden;
        int t1;
        bit ok;
        bit busy_bad, lat_bad;
        golden = 64'h8001_00FF_A5A5_1234;
        clear_rx();
        write_word(0, 16'h8001); write_word(1, 16'h00FF);
        write_word(2, 16'hA5A5); write_word(3, 16'h1234);
        end_frame(snap);
        t1 = cyc;
        busy_bad = 1'b0; lat_bad = 1'b0;
        for (int k = 1; k <= 135; k++) begin
            if (k > 1) @(negedge sys_clk);
            if (tx_busy !== ((k <= 131) ? 1'b1 : 1'b0)) begin
                if (!busy_bad) $display("FAIL basic_busy_t+%0d: got %b expected %b", k, tx_busy, (k <= 131));
                busy_bad = 1'b1;
            end
            if (led_lat !== ((k >= 130 && k <= 131) ? 1'b1 : 1'b0)) begin
                if (!lat_bad) $display("FAIL basic_lat_t+%0d: got %b expected %b", k, led_lat, (k >= 130 && k <= 131));
                lat_bad = 1'b1;
            end
            if (k == 2) begin
                tests++; if (led_sclk !== 1'b0 || led_sdi !== 1'b1) begin
                    fails++; $display("FAIL basic_first_bit: got sclk=%b sdi=%b expected sclk=0 sdi=1", led_sclk, led_sdi);
                end
            end
        end
        tests++; if (busy_bad) fails++;
        tests++; if (lat_bad) fails++;
        wait_rx(1, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL basic_rx: got no frame expected 1 frame");
        end else begin
            if (rx_q[0] !== golden) begin fails++; $display("FAIL basic_data: got %h expected %h", rx_q[0], golden); end
            tests++; if (rx_bits_q[0] != FW) begin fails++; $display("FAIL basic_bits: got %0d expected %0d", rx_bits_q[0], FW); end
            tests++; if (first_rise_q[0] != t1 + 2) begin
                fails++; $display("FAIL basic_first_rise: got cycle %0d expected %0d", first_rise_q[0], t1 + 2);
            end
        end
        wait_idle();
    endtask

    task automatic test_out_of_range();
        logic [FW-1:0] snap;
        bit ok;
        clear_rx();
        write_random_frame();
        write_word(4, 16'hFFFF);
        write_word(ZONES + 3, 16'hFFFF);
        end_frame(snap);
        wait_rx(1, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL oor_rx: got no frame expected 1 frame"); end
        else if (rx_q[0] !== snap) begin fails++; $display("FAIL oor_data: got %h expected %h", rx_q[0], snap); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] sa, sb;
        bit ok;
        clear_rx();
        write_random_frame();
        end_frame(sa);
        repeat (20) @(negedge sys_clk);
        write_random_frame();
        end_frame(sb);
        tests++; if (frame_drop !== 1'b0) begin fails++; $display("FAIL b2b_drop: got %b expected 0", frame_drop); end
        wait_rx(2, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL b2b_rx: got %0d frames expected 2", rx_q.size());
        end else begin
            if (rx_q[0] !== sa) begin fails++; $display("FAIL b2b_first: got %h expected %h", rx_q[0], sa); end
            tests++; if (rx_q[1] !== sb) begin fails++; $display("FAIL b2b_second: got %h expected %h", rx_q[1], sb); end
            tests++; if (first_rise_q[1] != lat_fall_q[0] + 2) begin
                fails++; $display("FAIL b2b_restart: got rise %0d expected %0d", first_rise_q[1], lat_fall_q[0] + 2);
            end
            tests++; if (busy_fall_q[0] !== 1'b1) begin fails++; $display("FAIL b2b_busy_gap: got %b expected 1", busy_fall_q[0]); end
        end
        wait_idle();
        tests++; if (drop_cnt != 0) begin fails++; $display("FAIL b2b_drop_count: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_drop();
        logic [FW-1:0] sc, sd, se;
        bit ok;
        clear_rx();
        write_random_frame();
        end_frame(sc);
        repeat (10) @(negedge sys_clk);
        write_random_frame();
        end_frame(sd);
        write_random_frame();
        end_frame(se);
        tests++; if (frame_drop !== 1'b1) begin fails++; $display("FAIL drop_pulse: got %b expected 1", frame_drop); end
        @(negedge sys_clk);
        tests++; if (frame_drop !== 1'b0) begin fails++; $display("FAIL drop_width: got %b expected 0", frame_drop); end
        wait_rx(2, ok);
        wait_idle();
        tests++;
        if (!ok || rx_q.size() != 2) begin
            fails++; $display("FAIL drop_frames: got %0d frames expected 2", rx_q.size());
        end else begin
            if (rx_q[0] !== sc) begin fails++; $display("FAIL drop_first: got %h expected %h", rx_q[0], sc); end
            tests++; if (rx_q[1] !== se) begin
                fails++; $display("FAIL drop_latest: got %h expected %h (superseded %h)", rx_q[1], se, sd);
            end
        end
        tests++; if (drop_cnt != 1) begin fails++; $display("FAIL drop_count: got %0d expected 1", drop_cnt); end
    endtask

    task automatic test_coincident_write();
        logic [FW-1:0] snap;
        bit ok;
        clear_rx();
        for (int i = 0; i < ZONES - 1; i++) write_word(i, DW'($urandom));
        write_word(3, 16'h0000);
        map_bus.get_map = 1'b1;
        map_bus.light_index = IDX_W'(3);
        map_bus.light = 16'h7777;
        model_words[3] = 16'h7777;
        end_frame(snap);
        map_bus.get_map = 1'b0;
        wait_rx(1, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL coinc_rx: got no frame expected 1 frame"); end
        else if (rx_q[0] !== snap) begin fails++; $display("FAIL coinc_data: got %h expected %h", rx_q[0], snap); end
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        logic [FW-1:0] snap;
        bit ok;
        clear_rx();
        write_random_frame();
        end_frame(snap);
        repeat (40) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        tests++; if ({led_sclk, led_sdi, led_lat, tx_busy, frame_drop} !== 5'b00000) begin
            fails++; $display("FAIL midrst_outputs: got %b expected 00000", {led_sclk, led_sdi, led_lat, tx_busy, frame_drop});
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        tests++; if (tx_busy !== 1'b0 || led_sclk !== 1'b0) begin
            fails++; $display("FAIL midrst_idle: got busy=%b sclk=%b expected 0 0", tx_busy, led_sclk);
        end
        clear_rx();
        write_random_frame();
        end_frame(snap);
        wait_rx(1, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL midrst_rx: got no frame expected 1 frame"); end
        else if (rx_q[0] !== snap || rx_bits_q[0] != FW) begin
            fails++; $display("FAIL midrst_data: got %h (%0d bits) expected %h", rx_q[0], rx_bits_q[0], snap);
        end
        wait_idle();
    endtask

    initial begin
        sys_rst = 1'b1;
        map_bus.get_map = 1'b0;
        map_bus.filter_end = 1'b0;
        map_bus.light = '0;
        map_bus.light_index = '0;
        for (int i = 0; i < ZONES; i++) model_words[i] = '0;
        @(negedge sys_clk);
        test_reset();
        test_basic_frame();
        test_out_of_range();
        test_back_to_back();
        test_drop();
        test_coincident_write();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
